profir_sequencer: RTL and testbench
===================================

# profir_sequencer

Control sequencer for the programmable 8-channel FIR bank. Each accepted input sample starts one pass over the 64 sample pairs of the 128-entry delay line. During the pass the block drives three things in lockstep:
- the coefficient-memory address;
- the sample-pair multiplexer select;
- the accumulator controls of the eight MAC lanes.

At the end of the pass it strobes the lane results into the output registers. It sits between the input handshake (`din_enable`) and the shared datapath: coefficient RAM, pair multiplexer and 8 MAC lanes.

## Interface
Parameters:
- `NPAIRS`, 64: sample pairs per pass. Equals the number of coefficient addresses.
- `RAM_LAT`, 1: read latency of the coefficient RAM, in cycles (≥1).
- `MAC_PIPE`, 2: multiplier pipeline stages before the accumulator (≥0).

Ports:
- `clock` in 1: clock. All logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `din_enable` in 1: new sample offered this cycle.
- `ovr_clear` in 1: clears the sticky `overrun` flag.
- `shift_en` out 1: delay-line shift/load enable. Equals `din_enable & ~busy`, combinational.
- `coeffaddress` out 6: coefficient RAM read address.
- `pair_sel` out 6: sample-pair mux select, aligned with RAM read data.
- `acc_en` out 1: accumulate enable for all 8 lanes.
- `acc_first` out 1: with `acc_en`, load the product instead of adding it (clears the accumulator).
- `dout_load` out 1: one-cycle pulse that latches the 8 accumulators into `dataout0..7`.
- `busy` out 1: a pass is in progress.
- `overrun` out 1: sticky flag; a sample arrived while busy and was dropped.

## Operation
States:
- **IDLE**
  - `busy`=0.
  - `din_enable`=1 asserts `shift_en` in the same cycle, and the state goes to RUN. The counter `k` is set to 0.
- **RUN**
  - `coeffaddress`=`k`, and `k` increments every cycle.
  - When `k`=NPAIRS-1, go to DRAIN with drain count RAM_LAT+MAC_PIPE.
- **DRAIN**
  - Issues no address. The count decrements each cycle.
  - When the count reaches 0, go to DONE.
- **DONE**
  - `dout_load`=1 for this single cycle, then go to IDLE.
  - `busy`=1 in DONE.

Pipeline alignment:
- A token {valid, first, last} enters a delay line alongside each issued address.
- `pair_sel` = the address delayed RAM_LAT cycles.
- `acc_en` and `acc_first` = valid and first delayed RAM_LAT+MAC_PIPE cycles.

Other rules:
- `coeffaddress` and `pair_sel` read 0 whenever no valid address or token occupies that stage.
- `busy`=1 in RUN, DRAIN and DONE.
- Overrun:
  - `din_enable` while `busy` gives `shift_en`=0, the sample is dropped, and `overrun` is set the next cycle.
  - `ovr_clear` clears `overrun`. If `ovr_clear` and a new overrun occur in the same cycle, set wins.
- Counter width is clog2(NPAIRS). No wrap past NPAIRS-1.
- Reset values:
  - All outputs 0, state IDLE, delay lines cleared, `overrun`=0.
  - Reset mid-pass aborts the pass. No `dout_load` is produced for it.

## Timing
Defaults (NPAIRS=64, RAM_LAT=1, MAC_PIPE=2), with the sample accepted at cycle T (`shift_en`=1):
- `busy`=1 from T+1 to T+68.
- `coeffaddress`=k at T+1+k, for k=0..63.
- `pair_sel`=k at T+2+k.
- `acc_en`=1 from T+4 to T+67; `acc_first`=1 only at T+4.
- `dout_load`=1 at T+68.
- Next sample acceptable at T+69.

General formulas:
- Pass length: NPAIRS+RAM_LAT+MAC_PIPE+1 busy cycles.
- Minimum sample spacing: NPAIRS+RAM_LAT+MAC_PIPE+2 cycles.

Edge cases:
- `din_enable` held high continuously: exactly one sample is accepted per spacing interval. All others set `overrun`.
- `din_enable` in the DONE cycle is dropped, because `busy`=1.

## Structure
- Package `profir_pkg` holds:
  - constants `NPAIRS`, `COEF_AW`=6, `NLANES`=8;
  - the state enum {IDLE, RUN, DRAIN, DONE}.
- Sub-module `profir_delay_line`: a parameterised width/depth register pipe with synchronous reset. Depth 0 is a pass-through. It is instantiated for the address path (depth RAM_LAT) and for the token path (depth RAM_LAT+MAC_PIPE).
- The FSM, the pass counter and the overrun flag stay in `profir_sequencer`.

## Test plan
- **Reset then single pulse.** Hold reset 3 cycles, then `din_enable` for 1 cycle at T. Expect:
  - `shift_en`=1 at T;
  - `coeffaddress` 0..63 at T+1..T+64, `pair_sel` 0..63 at T+2..T+65;
  - 64 `acc_en` cycles from T+4 with `acc_first` only at T+4;
  - `dout_load` only at T+68, `busy`=0 at T+69.
- **Overrun.** Pulse `din_enable` at T, then again at T+30. Expect:
  - `shift_en`=0 at T+30, `overrun`=1 from T+31;
  - the pass is unchanged;
  - `ovr_clear` at T+40 gives `overrun`=0 at T+41.
- **Back-to-back.** Hold `din_enable` high continuously. Expect `shift_en` pulses exactly 69 cycles apart, `dout_load` at each T+68, and `overrun` set.
- **Reset mid-pass.** Accept a sample at T, assert reset at T+20. Expect:
  - all outputs 0 from T+21;
  - no `dout_load`;
  - a new sample is accepted normally after reset releases.
- **Parameter sweep.** Run RAM_LAT=2, MAC_PIPE=0 and check:
  - `pair_sel`=k at T+3+k;
  - `acc_en` from T+3 to T+66;
  - `dout_load` at T+67.

Source files
------------

// File: rtl/profir_pkg.sv
// Shared constants and types for the programmable FIR bank sequencer.
package profir_pkg;

  localparam int NPAIRS  = 64;
  localparam int COEF_AW = 6;
  localparam int NLANES  = 8;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  // Travels alongside each issued address so lane controls stay aligned with data.
  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } token_t;

endpackage

// File: rtl/profir_delay_line.sv
// Fixed-depth register pipe with synchronous clear; depth 0 is a straight wire.
module profir_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_pass
      assign dout = din;
    end else begin : g_pipe
      logic [WIDTH-1:0] stage [DEPTH];

      // NOTE: every stage is cleared so no stale token can reach the lanes after an aborted pass.
      always_ff @(posedge clock) begin
        if (reset) begin
          for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else begin
          stage[0] <= din;
          for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
      end

      assign dout = stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/profir_sequencer.sv
// Per-sample pass controller: walks the coefficient addresses, aligns mux select
// and MAC lane controls to the RAM/multiplier pipeline, and strobes the results.
module profir_sequencer
  import profir_pkg::*;
#(
  parameter int NPAIRS   = profir_pkg::NPAIRS,
  parameter int RAM_LAT  = 1,
  parameter int MAC_PIPE = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               din_enable,
  input  logic               ovr_clear,
  output logic               shift_en,
  output logic [COEF_AW-1:0] coeffaddress,
  output logic [COEF_AW-1:0] pair_sel,
  output logic               acc_en,
  output logic               acc_first,
  output logic               dout_load,
  output logic               busy,
  output logic               overrun
);

  localparam int KW      = $clog2(NPAIRS);
  localparam int DRAIN_N = RAM_LAT + MAC_PIPE;
  localparam int DW      = $clog2(DRAIN_N + 1);

  state_t        state;
  logic [KW-1:0] k;
  logic [DW-1:0] drain_cnt;
  token_t        tok_in;
  token_t        tok_out;
  logic          unused_last;

  assign busy     = (state != IDLE);
  assign shift_en = din_enable & ~busy;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      k         <= '0;
      drain_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (din_enable) begin
            state <= RUN;
            k     <= '0;
          end
        end
        RUN: begin
          if (k == KW'(NPAIRS - 1)) begin
            state     <= DRAIN;
            k         <= '0;
            drain_cnt <= DW'(DRAIN_N);
          end else begin
            k <= k + 1'b1;
          end
        end
        DRAIN: begin
          if (drain_cnt == DW'(1)) begin
            state     <= DONE;
            drain_cnt <= '0;
          end else begin
            drain_cnt <= drain_cnt - 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // A drop while busy wins over a same-cycle clear.
  always_ff @(posedge clock) begin
    if (reset)                    overrun <= 1'b0;
    else if (din_enable && busy)  overrun <= 1'b1;
    else if (ovr_clear)           overrun <= 1'b0;
  end

  // k is held at 0 outside RUN, so the address reads 0 whenever nothing is issued.
  assign coeffaddress = COEF_AW'(k);
  assign dout_load    = (state == DONE);

  assign tok_in.valid = (state == RUN);
  assign tok_in.first = (state == RUN) && (k == '0);
  assign tok_in.last  = (state == RUN) && (k == KW'(NPAIRS - 1));

  profir_delay_line #(
    .WIDTH (COEF_AW),
    .DEPTH (RAM_LAT)
  ) u_addr_dly (
    .clock (clock),
    .reset (reset),
    .din   (coeffaddress),
    .dout  (pair_sel)
  );

  profir_delay_line #(
    .WIDTH ($bits(token_t)),
    .DEPTH (RAM_LAT + MAC_PIPE)
  ) u_tok_dly (
    .clock (clock),
    .reset (reset),
    .din   (tok_in),
    .dout  (tok_out)
  );

  assign acc_en    = tok_out.valid;
  assign acc_first = tok_out.first;
  // The end-of-pass marker rides along for lanes that need it; the strobe comes from DONE.
  assign unused_last = tok_out.last;

endmodule

// File: tb/tb_profir_sequencer.sv
// Checks two sequencer configurations against a timing-window reference model.
module tb_profir_sequencer;

  localparam int NP = 64;

  logic clock = 1'b0;
  logic reset, din_enable, ovr_clear;

  logic       shift_a, acc_en_a, acc_first_a, dout_load_a, busy_a, overrun_a;
  logic [5:0] coeff_a, pair_a;
  logic       shift_b, acc_en_b, acc_first_b, dout_load_b, busy_b, overrun_b;
  logic [5:0] coeff_b, pair_b;

  always #5 clock = ~clock;

  profir_sequencer #(.NPAIRS(NP), .RAM_LAT(1), .MAC_PIPE(2)) dut_a (
    .clock(clock), .reset(reset), .din_enable(din_enable), .ovr_clear(ovr_clear),
    .shift_en(shift_a), .coeffaddress(coeff_a), .pair_sel(pair_a), .acc_en(acc_en_a),
    .acc_first(acc_first_a), .dout_load(dout_load_a), .busy(busy_a), .overrun(overrun_a)
  );

  profir_sequencer #(.NPAIRS(NP), .RAM_LAT(2), .MAC_PIPE(0)) dut_b (
    .clock(clock), .reset(reset), .din_enable(din_enable), .ovr_clear(ovr_clear),
    .shift_en(shift_b), .coeffaddress(coeff_b), .pair_sel(pair_b), .acc_en(acc_en_b),
    .acc_first(acc_first_b), .dout_load(dout_load_b), .busy(busy_b), .overrun(overrun_b)
  );

  // Reference model: per configuration, the cycle the last sample was accepted.
  int ram_lat  [2] = '{1, 2};
  int mac_pipe [2] = '{2, 0};
  bit act      [2];
  int acc_t    [2];
  bit ovr      [2];
  int cyc      = 0;
  int n_cmp    = 0;
  int n_bad    = 0;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic bit busy_exp(input int i);
    int d = cyc - acc_t[i];
    return act[i] && d >= 1 && d <= NP + ram_lat[i] + mac_pipe[i] + 1;
  endfunction

  task automatic check_inst(input int i, input logic shift, input logic [5:0] coeff,
                            input logic [5:0] pair, input logic en, input logic first,
                            input logic load, input logic bsy, input logic ov);
    int  d  = act[i] ? cyc - acc_t[i] : -1000;
    int  r  = ram_lat[i];
    int  dl = ram_lat[i] + mac_pipe[i];
    int  e_coeff = (d >= 1 && d <= NP) ? d - 1 : 0;
    int  e_pair  = (d >= 1 + r && d <= NP + r) ? d - 1 - r : 0;
    string p = (i == 0) ? "a" : "b";
    check({p, ".busy"},      8'(bsy),   8'(busy_exp(i)));
    check({p, ".shift_en"},  8'(shift), 8'(din_enable & ~busy_exp(i)));
    check({p, ".coeffaddr"}, 8'(coeff), 8'(e_coeff));
    check({p, ".pair_sel"},  8'(pair),  8'(e_pair));
    check({p, ".acc_en"},    8'(en),    8'(d >= 1 + dl && d <= NP + dl));
    check({p, ".acc_first"}, 8'(first), 8'(d == 1 + dl));
    check({p, ".dout_load"}, 8'(load),  8'(d == NP + dl + 1));
    check({p, ".overrun"},   8'(ov),    8'(ovr[i]));
  endtask

  task automatic model_update(input int i, input bit din, input bit clr, input bit rst);
    bit b = busy_exp(i);
    if (rst) begin
      act[i] = 1'b0;
      ovr[i] = 1'b0;
    end else begin
      if (din && !b) begin
        act[i]   = 1'b1;
        acc_t[i] = cyc;
      end
      if (din && b)  ovr[i] = 1'b1;
      else if (clr)  ovr[i] = 1'b0;
    end
  endtask

  task automatic tick(input bit din, input bit clr, input bit rst);
    din_enable = din;
    ovr_clear  = clr;
    reset      = rst;
    @(negedge clock);
    check_inst(0, shift_a, coeff_a, pair_a, acc_en_a, acc_first_a, dout_load_a, busy_a, overrun_a);
    check_inst(1, shift_b, coeff_b, pair_b, acc_en_b, acc_first_b, dout_load_b, busy_b, overrun_b);
    for (int i = 0; i < 2; i++) model_update(i, din, clr, rst);
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    reset      = 1'b1;
    din_enable = 1'b0;
    ovr_clear  = 1'b0;
    @(posedge clock);
    #1;

    // Reset held, then a single sample and a full pass.
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b1);
    tick(1'b1, 1'b0, 1'b0);
    idle(75);

    // Drop at T+30, clear at T+40, then a clear racing a new drop.
    tick(1'b1, 1'b0, 1'b0);
    idle(29);
    tick(1'b1, 1'b0, 1'b0);
    idle(9);
    tick(1'b0, 1'b1, 1'b0);
    idle(5);
    tick(1'b1, 1'b1, 1'b0);
    idle(35);

    // Held request: one acceptance per spacing interval.
    for (int i = 0; i < 3 * 69 + 5; i++) tick(1'b1, 1'b0, 1'b0);
    idle(75);
    tick(1'b0, 1'b1, 1'b0);

    // Reset in the middle of a pass, then a normal pass.
    tick(1'b1, 1'b0, 1'b0);
    idle(19);
    tick(1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b1);
    idle(3);
    tick(1'b1, 1'b0, 1'b0);
    idle(75);

    // Random traffic: sparse pulses, bursts, clears and rare resets.
    for (int i = 0; i < 1500; i++) begin
      bit din = ($urandom_range(0, 99) < 4) || (($urandom_range(0, 9) == 0) && din_enable);
      bit clr = ($urandom_range(0, 29) == 0);
      bit rst = ($urandom_range(0, 499) == 0);
      tick(din, clr, rst);
    end
    idle(75);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
